peripheral_dma_desc_ahb4: RTL and testbench
===========================================

// Module: peripheral_dma_desc_ahb4
// PURPOSE
//  AHB4-Lite slave that turns bus writes into DMA transfer descriptors for the DMA core.
//  Upstream: the AHB4 master/BFM (HSEL..HRESP). Downstream: DMA channel engine via valid/ready.
//  Software stages SRC/DST, then writes LEN, which pushes {src,dst,len} into a DEPTH-entry FIFO.
// PARAMETERS
//  HADDR_SIZE  16  AHB address width; decode uses HADDR[4:2], upper bits ignored
//  HDATA_SIZE  32  AHB data width; also src/dst/len width
//  DEPTH       4   descriptor FIFO entries, power of 2, >=2
// PORTS
//  HCLK        in   1           bus clock; all state on rising edge
//  HRESET      in   1           asynchronous, active-high reset
//  HSEL        in   1           slave select
//  HADDR       in   HADDR_SIZE  address
//  HWDATA      in   HDATA_SIZE  write data (data phase)
//  HRDATA      out  HDATA_SIZE  read data (data phase)
//  HWRITE      in   1           1=write
//  HSIZE       in   3           transfer size; only 3'b010 legal
//  HBURST      in   3           ignored (each beat decoded singly)
//  HPROT       in   4           ignored
//  HTRANS      in   2           IDLE/BUSY ignored; NONSEQ/SEQ accepted
//  HMASTLOCK   in   1           ignored
//  HREADY      in   1           bus ready (HREADYOUT looped back)
//  HREADYOUT   out  1           slave ready
//  HRESP       out  1           0=OKAY 1=ERROR
//  desc_valid  out  1           FIFO head valid
//  desc_ready  in   1           engine accepts head when valid&ready
//  desc_src    out  HDATA_SIZE  head source address
//  desc_dst    out  HDATA_SIZE  head destination address
//  desc_len    out  HDATA_SIZE  head byte length
//  irq         out  1           FIFO-empty interrupt (see CONFIGURATION)
// BEHAVIOUR
//  Reset: HREADYOUT=1, HRESP=0, HRDATA=0, desc_valid=0, desc_*=0, irq=0, SRC=DST=0, count=0.
//  Map (HADDR[4:2]): 0 SRC rw; 1 DST rw; 2 LEN wo (write=push, reads 0); 3 STATUS ro
//   {..,full[9],empty[8],count[7:0]}; 4 IRQ ctrl (macro); others unmapped.
//  Address phase accepted when HSEL&HREADY&HTRANS[1]; addr/write/size registered.
//  FSM: IDLE -> DATA on accept. DATA: read -> HRDATA valid, HREADYOUT=1, zero wait.
//   Write SRC/DST: latched from HWDATA this cycle. Write LEN with FIFO not full:
//   push {SRC,DST,HWDATA}, HREADYOUT=1. LEN with full -> WAIT: HREADYOUT=0 until
//   registered count<DEPTH, then push and HREADYOUT=1 (min 1 wait state).
//   Back-to-back accept in DATA's final cycle stays in DATA.
//  Unmapped addr, HSIZE!=3'b010, write to STATUS: ERR1 (HREADYOUT=0,HRESP=1) ->
//   ERR2 (HREADYOUT=1,HRESP=1) -> IDLE/DATA; no state change, no push.
//  FIFO: pop on desc_valid&desc_ready; push+pop same cycle: count unchanged.
//   Full is registered: pop in a WAIT cycle releases the push the following cycle.
//   Pointers wrap modulo DEPTH; desc_valid = count!=0; head outputs are registered.
//  Pop while empty: ignored. Reset mid-WAIT: transfer dropped, FIFO emptied, outputs reset.
// CONFIGURATION
//  PERIPHERAL_DMA_DESC_IRQ_EN defined: reg 4 bit0=irq_en (rw, reset 0), bit1=pending
//   (w1c); pending set on transition count 1->0 via pop; irq=irq_en&pending.
//  Undefined: irq tied 0; reg 4 reads 0, writes ignored, OKAY (not an error).
// TESTING
//  Write SRC=0x1000, DST=0x2000, LEN=0x40, desc_ready=0 -> desc_valid=1, head=1000/2000/40, count=1.
//  Push 4 descs, 5th LEN write -> HREADYOUT low; pulse desc_ready 1 cycle -> push next cycle, count=4.
//  Read STATUS empty -> 0x100; after 4 pushes -> 0x204; HRDATA with 0 wait states.
//  Read HADDR=0x1C or HSIZE=3'b000 -> two-cycle ERROR (HRESP 1,1; HREADYOUT 0,1), no state change.
//  IRQ_EN: enable, push 1, pop -> irq=1; write 0x2 to reg 4 -> irq=0. Without macro irq stays 0.
//  Assert HRESET during WAIT -> HREADYOUT=1, desc_valid=0, count=0 immediately.

Source files
------------

// File: rtl/peripheral_dma_desc_ahb4.sv
// AHB4-Lite slave that stages SRC/DST and pushes {src,dst,len} descriptors into a FIFO on LEN writes.
// Optional FIFO-empty interrupt register enabled by defining PERIPHERAL_DMA_DESC_IRQ_EN.
module peripheral_dma_desc_ahb4 #(
    parameter int HADDR_SIZE = 16,
    parameter int HDATA_SIZE = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    output logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HMASTLOCK,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic                  desc_valid,
    input  logic                  desc_ready,
    output logic [HDATA_SIZE-1:0] desc_src,
    output logic [HDATA_SIZE-1:0] desc_dst,
    output logic [HDATA_SIZE-1:0] desc_len,
    output logic                  irq
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {S_IDLE, S_DATA, S_WAIT, S_ERR1, S_ERR2} state_t;

    state_t                  state, nstate;
    logic   [2:0]            d_idx;
    logic                    d_write;
    logic   [HDATA_SIZE-1:0] src_r, dst_r;
    logic   [AW-1:0]         wp, rp;
    logic   [CW-1:0]         count;
    logic   [3*HDATA_SIZE-1:0] mem [DEPTH];
    logic                    accept, a_err, push, pop, full, empty;
    logic   [2:0]            a_idx;
    logic   [3*HDATA_SIZE-1:0] push_data;

    logic unused;
    assign unused = ^{HADDR[HADDR_SIZE-1:5], HADDR[1:0], HTRANS[0], HBURST, HPROT, HMASTLOCK};

    assign accept    = HSEL & HREADY & HTRANS[1];
    assign a_idx     = HADDR[4:2];
    assign a_err     = (HSIZE != 3'b010) | (a_idx > 3'd4) | (HWRITE & (a_idx == 3'd3));
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign desc_valid = ~empty;
    assign pop       = desc_valid & desc_ready;
    assign push_data = {src_r, dst_r, HWDATA};

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state   <= S_IDLE;
            d_idx   <= '0;
            d_write <= 1'b0;
        end else begin
            state <= nstate;
            if (accept) begin
                d_idx   <= a_idx;
                d_write <= HWRITE;
            end
        end
    end

    always_comb begin
        nstate    = state;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        push      = 1'b0;
        case (state)
            S_IDLE: if (accept) nstate = a_err ? S_ERR1 : S_DATA;
            S_DATA: begin
                if (d_write && d_idx == 3'd2 && full) begin
                    HREADYOUT = 1'b0;
                    nstate    = S_WAIT;
                end else begin
                    push   = d_write && (d_idx == 3'd2);
                    nstate = accept ? (a_err ? S_ERR1 : S_DATA) : S_IDLE;
                end
            end
            // full is registered, so a pop seen here frees the slot one cycle later
            S_WAIT: begin
                if (full) begin
                    HREADYOUT = 1'b0;
                end else begin
                    push   = 1'b1;
                    nstate = accept ? (a_err ? S_ERR1 : S_DATA) : S_IDLE;
                end
            end
            S_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                nstate    = S_ERR2;
            end
            S_ERR2: begin
                HRESP  = 1'b1;
                nstate = accept ? (a_err ? S_ERR1 : S_DATA) : S_IDLE;
            end
            default: nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            src_r <= '0;
            dst_r <= '0;
        end else if (state == S_DATA && d_write) begin
            if (d_idx == 3'd0) src_r <= HWDATA;
            if (d_idx == 3'd1) dst_r <= HWDATA;
        end
    end

    always_ff @(posedge HCLK) begin
        if (push) mem[wp] <= push_data;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            desc_src <= '0;
            desc_dst <= '0;
            desc_len <= '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop)  rp <= rp + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // head tracks the entry that will be at rp after this edge
            if (push && (empty || (pop && count == CW'(1))))
                {desc_src, desc_dst, desc_len} <= push_data;
            else if (pop && count > CW'(1))
                {desc_src, desc_dst, desc_len} <= mem[rp + AW'(1)];
        end
    end

    logic [HDATA_SIZE-1:0] irq_reg;
`ifdef PERIPHERAL_DMA_DESC_IRQ_EN
    logic irq_en, irq_pend;
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            irq_en   <= 1'b0;
            irq_pend <= 1'b0;
        end else begin
            if (state == S_DATA && d_write && d_idx == 3'd4) begin
                irq_en <= HWDATA[0];
                if (HWDATA[1]) irq_pend <= 1'b0;
            end
            if (pop && !push && count == CW'(1)) irq_pend <= 1'b1;
        end
    end
    assign irq     = irq_en & irq_pend;
    assign irq_reg = HDATA_SIZE'({irq_pend, irq_en});
`else
    assign irq     = 1'b0;
    assign irq_reg = '0;
`endif

    always_comb begin
        HRDATA = '0;
        if (state == S_DATA && !d_write) begin
            case (d_idx)
                3'd0:    HRDATA = src_r;
                3'd1:    HRDATA = dst_r;
                3'd3:    HRDATA = HDATA_SIZE'({full, empty, 8'(count)});
                3'd4:    HRDATA = irq_reg;
                default: HRDATA = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_peripheral_dma_desc_ahb4.sv
// Scoreboarded bench: stimulus queues expected bus responses and descriptors; monitors compare.
module tb_peripheral_dma_desc_ahb4;
    localparam int DEPTH = 4;

    logic        HCLK = 0, HRESET = 1, HSEL = 0, HWRITE = 0, HMASTLOCK = 0, desc_ready = 0;
    logic [15:0] HADDR = 0;
    logic [31:0] HWDATA = 0;
    logic [2:0]  HSIZE = 3'b010, HBURST = 0;
    logic [3:0]  HPROT = 0;
    logic [1:0]  HTRANS = 0;
    logic        HREADY, HREADYOUT, HRESP, desc_valid, irq;
    logic [31:0] HRDATA, desc_src, desc_dst, desc_len;

    assign HREADY = HREADYOUT;
    always #5 HCLK = ~HCLK;

    peripheral_dma_desc_ahb4 #(.HADDR_SIZE(16), .HDATA_SIZE(32), .DEPTH(DEPTH)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
        .HRESP(HRESP), .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_src(desc_src),
        .desc_dst(desc_dst), .desc_len(desc_len), .irq(irq));

    typedef struct { bit wr; logic [15:0] addr; logic [2:0] size; logic [31:0] wdata; } req_t;
    typedef struct { bit wr; bit err; logic [31:0] rdata; int minw; int maxw; } exp_t;
    typedef struct { logic [31:0] s, d, l; } desc_t;

    req_t  reqs[$];
    exp_t  exp_bus[$];
    desc_t exp_desc[$];
    int    n_cmp = 0, n_bad = 0;
    bit    loose = 0, rand_on = 0;
    logic [31:0] src_m = 0, dst_m = 0;
    int    cnt_m = 0;
    bit    en_m = 0, pend_m = 0;
`ifdef PERIPHERAL_DMA_DESC_IRQ_EN
    localparam bit IRQ_ON = 1;
`else
    localparam bit IRQ_ON = 0;
`endif

    task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
        end
    endtask

    // reference model: register map and FIFO occupancy in plain terms
    task automatic issue(bit wr, logic [15:0] addr, logic [2:0] size, logic [31:0] wd);
        exp_t e;
        int idx = int'(addr[4:2]);
        e.wr = wr; e.rdata = 0; e.minw = 0; e.maxw = 0;
        e.err = (size != 3'b010) || idx > 4 || (wr && idx == 3);
        if (e.err) begin
            e.minw = 1; e.maxw = 1;
        end else if (wr) begin
            if (idx == 0) src_m = wd;
            if (idx == 1) dst_m = wd;
            if (idx == 2) begin
                exp_desc.push_back('{src_m, dst_m, wd});
                if (loose) e.maxw = 1000;
                else if (cnt_m >= DEPTH) begin e.minw = 1; e.maxw = 1000; end
                cnt_m++;
            end
            if (idx == 4 && IRQ_ON) begin
                en_m = wd[0];
                if (wd[1]) pend_m = 0;
            end
        end else begin
            if (idx == 0) e.rdata = src_m;
            if (idx == 1) e.rdata = dst_m;
            if (idx == 3) e.rdata = (cnt_m == DEPTH ? 32'h200 : 0) | (cnt_m == 0 ? 32'h100 : 0) | cnt_m;
            if (idx == 4 && IRQ_ON) e.rdata = {30'b0, pend_m, en_m};
        end
        exp_bus.push_back(e);
        reqs.push_back('{wr, addr, size, wd});
    endtask

    task automatic wait_rdy();
        int g = 0;
        while (!HREADYOUT && g < 300) begin @(posedge HCLK); #1; g++; end
        if (!HREADYOUT) begin
            n_cmp++; n_bad++;
            $display("FAIL hready_timeout: got 0 want 1 within 300 cycles");
        end
    endtask

    // pipelined AHB master: next address phase overlaps the current data phase
    task automatic run();
        req_t r;
        while (reqs.size() > 0) begin
            r = reqs.pop_front();
            HSEL = 1; HADDR = r.addr; HWRITE = r.wr; HSIZE = r.size;
            HTRANS = {1'b1, rand_on ? 1'($urandom_range(0, 1)) : 1'b0};
            wait_rdy();
            @(posedge HCLK); #1;
            HWDATA = r.wr ? r.wdata : $urandom;
            if (reqs.size() == 0) begin HSEL = 0; HTRANS = 2'b00; end
        end
        wait_rdy();
        @(posedge HCLK); #1;
    endtask

    task automatic pulse_ready();
        desc_ready = 1;
        @(posedge HCLK); #1;
        desc_ready = 0;
        if (cnt_m == 1 && IRQ_ON) pend_m = 1;
        cnt_m--;
    endtask

    task automatic rnd_op();
        int k = $urandom_range(0, 9);
        logic [15:0] hi = 16'($urandom);
        logic [31:0] d = $urandom;
        logic [2:0] ix;
        case (k)
            0, 1: issue(1, {hi[15:5], 3'd0, 2'b00}, 3'b010, d);
            2, 3: issue(1, {hi[15:5], 3'd1, 2'b00}, 3'b010, d);
            4, 5: issue(1, {hi[15:5], 3'd2, 2'b00}, 3'b010, d);
            6:    issue(0, {hi[15:5], 3'd0, 2'b00}, 3'b010, d);
            7:    issue(0, {hi[15:5], 3'd1, 2'b00}, 3'b010, d);
            8:    issue(0, {hi[15:5], 3'd2, 2'b00}, 3'b010, d);
            default: begin
                ix = 3'($urandom_range(5, 7));
                case ($urandom_range(0, 2))
                    0: issue(d[0], {hi[15:5], ix, 2'b00}, 3'b010, d);
                    1: issue(0, {hi[15:5], 3'd0, 2'b00}, 3'b000, d);
                    default: issue(1, {hi[15:5], 3'd3, 2'b00}, 3'b010, d);
                endcase
            end
        endcase
    endtask

    // bus monitor
    bit   in_dp = 0;
    int   waits = 0;
    exp_t me;
    always @(negedge HCLK) begin
        if (HRESET) begin
            in_dp = 0;
        end else begin
            if (in_dp) begin
                if (exp_bus.size() == 0) begin
                    if (HREADYOUT) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_completion: got transfer want none");
                    end
                end else if (!HREADYOUT) begin
                    waits++;
                    chk("resp_wait", {31'b0, HRESP}, {31'b0, exp_bus[0].err});
                end else begin
                    me = exp_bus.pop_front();
                    chk("resp", {31'b0, HRESP}, {31'b0, me.err});
                    if (!me.wr && !me.err) chk("rdata", HRDATA, me.rdata);
                    n_cmp++;
                    if (waits < me.minw || waits > me.maxw) begin
                        n_bad++;
                        $display("FAIL wait_states: got %0d want %0d..%0d", waits, me.minw, me.maxw);
                    end
                end
                if (HREADYOUT) in_dp = 0;
            end
            if (HSEL && HREADYOUT && HTRANS[1]) begin in_dp = 1; waits = 0; end
        end
    end

    // descriptor monitor
    desc_t md;
    always @(negedge HCLK) begin
        if (!HRESET && desc_valid && desc_ready) begin
            if (exp_desc.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL desc_extra: got %h want none", desc_len);
            end else begin
                md = exp_desc.pop_front();
                chk("desc_src", desc_src, md.s);
                chk("desc_dst", desc_dst, md.d);
                chk("desc_len", desc_len, md.l);
            end
        end
    end

    always @(posedge HCLK) if (rand_on) begin #1; desc_ready = 1'($urandom_range(0, 1)); end

    initial begin
        int g;
        repeat (3) @(posedge HCLK); #1;
        chk("rst_hreadyout", {31'b0, HREADYOUT}, 1);
        chk("rst_hresp", {31'b0, HRESP}, 0);
        chk("rst_hrdata", HRDATA, 0);
        chk("rst_valid", {31'b0, desc_valid}, 0);
        chk("rst_src", desc_src, 0);
        chk("rst_len", desc_len, 0);
        chk("rst_irq", {31'b0, irq}, 0);
        HRESET = 0;
        @(posedge HCLK); #1;

        issue(0, 16'h000C, 3'b010, 0);
        issue(1, 16'h0000, 3'b010, 32'h1000);
        issue(1, 16'h0004, 3'b010, 32'h2000);
        issue(1, 16'h0008, 3'b010, 32'h40);
        run();
        chk("head_valid", {31'b0, desc_valid}, 1);
        chk("head_src", desc_src, 32'h1000);
        chk("head_dst", desc_dst, 32'h2000);
        chk("head_len", desc_len, 32'h40);
        issue(0, 16'h000C, 3'b010, 0);
        issue(0, 16'h0008, 3'b010, 0);
        issue(0, 16'hFFE0, 3'b010, 0);
        issue(1, 16'h0008, 3'b010, 32'h41);
        issue(1, 16'h0008, 3'b010, 32'h42);
        issue(1, 16'h0008, 3'b010, 32'h43);
        issue(0, 16'h000C, 3'b010, 0);
        run();

        // fifth LEN stalls until one pop frees a slot
        issue(1, 16'h0008, 3'b010, 32'h44);
        fork
            run();
            begin
                repeat (4) @(posedge HCLK); #1;
                chk("full_stall", {31'b0, HREADYOUT}, 0);
                pulse_ready();
            end
        join
        issue(0, 16'h000C, 3'b010, 0);
        issue(0, 16'h001C, 3'b010, 0);
        issue(0, 16'h0000, 3'b000, 0);
        issue(1, 16'h000C, 3'b010, 32'hFF);
        issue(1, 16'h0014, 3'b010, 32'h77);
        issue(0, 16'h000C, 3'b010, 0);
        issue(0, 16'h0000, 3'b010, 0);
        run();

        // reset while a LEN write is held in wait states
        HSEL = 1; HTRANS = 2'b10; HADDR = 16'h0008; HWRITE = 1; HSIZE = 3'b010;
        @(posedge HCLK); #1;
        HSEL = 0; HTRANS = 2'b00; HWDATA = 32'h99;
        @(posedge HCLK); #1;
        chk("wait_before_rst", {31'b0, HREADYOUT}, 0);
        HRESET = 1;
        #1;
        chk("rst_wait_hready", {31'b0, HREADYOUT}, 1);
        chk("rst_wait_valid", {31'b0, desc_valid}, 0);
        chk("rst_wait_hresp", {31'b0, HRESP}, 0);
        exp_desc.delete();
        cnt_m = 0; src_m = 0; dst_m = 0; en_m = 0; pend_m = 0;
        @(posedge HCLK); #1;
        HRESET = 0;
        @(posedge HCLK); #1;
        issue(0, 16'h000C, 3'b010, 0);
        issue(0, 16'h0000, 3'b010, 0);
        issue(1, 16'h0010, 3'b010, 32'h1);
        issue(1, 16'h0000, 3'b010, 32'h5);
        issue(1, 16'h0004, 3'b010, 32'h6);
        issue(1, 16'h0008, 3'b010, 32'h7);
        run();
        pulse_ready();
        chk("irq_after_pop", {31'b0, irq}, {31'b0, IRQ_ON});
        issue(0, 16'h0010, 3'b010, 0);
        issue(1, 16'h0010, 3'b010, 32'h2);
        run();
        chk("irq_cleared", {31'b0, irq}, 0);
        issue(0, 16'h0010, 3'b010, 0);
        issue(0, 16'h000C, 3'b010, 0);
        run();

        // randomized traffic with random downstream backpressure
        loose = 1; rand_on = 1;
        repeat (15) begin
            repeat ($urandom_range(1, 6)) rnd_op();
            run();
            repeat ($urandom_range(0, 2)) @(posedge HCLK);
            #1;
        end
        rand_on = 0;
        @(posedge HCLK); #2;
        desc_ready = 1;
        g = 0;
        while (exp_desc.size() > 0 && g < 200) begin @(posedge HCLK); g++; end
        #2 desc_ready = 0;
        if (exp_desc.size() > 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain: got %0d left want 0", exp_desc.size());
        end
        @(posedge HCLK); #1;
        loose = 0; cnt_m = 0;
        chk("final_valid", {31'b0, desc_valid}, 0);
        issue(0, 16'h000C, 3'b010, 0);
        run();
        repeat (2) @(posedge HCLK);
        if (exp_bus.size() > 0) begin
            n_cmp++; n_bad++;
            $display("FAIL bus_left: got %0d pending want 0", exp_bus.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
